load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory stage of the core. Sits between `alu` and `wb`: accepts one load or store per transaction from the ALU (effective address, store data, destination register, funct3), issues a single 64-bit request to the data-side memory port, and returns aligned, sign/zero-extended load data plus destination register to write-back (`lddata_in` / `rd_mem`). It stalls upstream through a valid/ready handshake while a transaction is outstanding.

## Interface
- `ADDRSZ`, 64, address width
- `WORDSZ`, 64, data width
- `REGSZ`, 5, register index width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  ALU presents a memory op
- `in_ready`  out  1  LSU can accept (IDLE)
- `in_is_store`  in  1  1=store, 0=load
- `in_funct3`  in  3  size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LD/SD 011, LBU 100, LHU 101, LWU 110
- `in_addr`  in  ADDRSZ  effective address
- `in_wdata`  in  WORDSZ  store data, right-justified
- `in_rd`  in  REGSZ  load destination
- `dreq_valid`  out  1  memory request
- `dreq_ready`  in  1  memory accepts request
- `dreq_addr`  out  ADDRSZ  doubleword-aligned address (`addr[2:0]`=0)
- `dreq_we`  out  1  write request
- `dreq_wdata`  out  WORDSZ  lane-shifted store data
- `dreq_wstrb`  out  8  byte enables
- `dresp_valid`  in  1  read data / write ack
- `dresp_rdata`  in  WORDSZ  read doubleword
- `out_valid`  out  1  one-cycle completion pulse
- `out_wr_en`  out  1  write-back enable (loads to rd≠0 only)
- `out_rd`  out  REGSZ  destination
- `out_data`  out  WORDSZ  extended load result
- `out_misaligned`  out  1  access faulted, no memory op issued

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `in_ready`=1. `in_valid` → latch all inputs. Aligned → REQ; misaligned (H: `addr[0]`≠0, W: `addr[1:0]`≠0, D: `addr[2:0]`≠0) → DONE with `out_misaligned`=1.
- REQ: `dreq_valid`=1, request fields stable; `dreq_ready` → WAIT.
- WAIT: hold until `dresp_valid`; latch `dresp_rdata` → DONE.
- DONE: `out_valid`=1 for one cycle → IDLE.
- Store: `off=addr[2:0]`; `dreq_wdata = in_wdata << (8*off)`; `wstrb` = size mask (0x01/0x03/0x0F/0xFF) `<< off`; `out_wr_en`=0.
- Load: `dreq_wstrb`=0, `dreq_we`=0; `raw = rdata >> (8*off)`; extract 8/16/32/64 bits; sign-extend funct3 000/001/010, zero-extend 100/101/110.
- `out_wr_en` = load & !misaligned & rd≠0. `out_data`=0 for stores and faults.
- funct3 111, or 100–110 on a store: treated as misaligned fault.

## Timing
- Reset: state IDLE; `in_ready`=1; every other output 0.
- Best case: accept cycle 0, `dreq_valid` cycle 1 (ready same cycle), `dresp_valid` cycle 2, `out_valid` cycle 3.
- Misaligned: accept cycle 0, `out_valid` cycle 1.
- `dreq_*` held constant while `dreq_valid` & !`dreq_ready`.
- `dresp_valid` is sampled only in WAIT; it is ignored in IDLE, REQ, and DONE.
- `in_ready`=0 in REQ/WAIT/DONE. A new op can be accepted the cycle after DONE.
- Reset mid-transaction: IDLE next cycle, `dreq_valid` drops, no `out_valid`; a stale `dresp_valid` arriving afterwards is ignored.

## Structure
- `lsu_pkg`: state enum, funct3 constants, `size_mask` function.
- Sub-module `lsu_align`, combinational: store shift/strobe and load extract/extend. It is shared by both paths and unit-testable on its own.
- FSM and latches live in `load_store_unit`.

## Test plan
- SW: addr 0x1004, wdata 0xDEADBEEF → `dreq_addr` 0x1000, wdata 0xDEADBEEF_00000000, wstrb 0xF0, `out_wr_en`=0.
- LB: addr 0x2003, rdata 0x00000000_80000000 → `out_data` 0xFFFFFFFF_FFFFFF80, `out_wr_en`=1. The same access as LBU → 0x80.
- LD: addr 0x3000, rd=0 → `out_wr_en`=0, `out_valid` pulses once, 3-cycle latency with immediate ready/resp.
- LH: addr 0x4001 → `out_misaligned`=1 at cycle 1, `dreq_valid` never asserted.
- `dreq_ready` held low 5 cycles → request fields stable and `in_ready`=0 throughout; stray `dresp_valid` in REQ is ignored.
- Reset asserted in WAIT → `dreq_valid` 0, no `out_valid`; following `dresp_valid` ignored; next op completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings,
// byte-mask and access-fault decode used by both the FSM and the lane aligner.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Right-justified byte enables for an access of 1/2/4/8 bytes (funct3[1:0]).
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Unsupported encodings share the misaligned fault path so no memory op is issued.
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [2:0] off);
      logic bad;
      bad = 1'b0;
      if (funct3 == 3'b111 || (is_store && funct3[2])) begin
         bad = 1'b1;
      end else begin
         case (funct3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            2'b11:   bad = |off;
            default: bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-side memory port: one request channel and one response channel.
// The LSU is the master; the memory (or a bench model) is the slave.
interface lsu_dmem_if #(
   parameter int ADDRSZ = 64,
   parameter int WORDSZ = 64
);
   logic                  dreq_valid;
   logic                  dreq_ready;
   logic [ADDRSZ-1:0]     dreq_addr;
   logic                  dreq_we;
   logic [WORDSZ-1:0]     dreq_wdata;
   logic [WORDSZ/8-1:0]   dreq_wstrb;
   logic                  dresp_valid;
   logic [WORDSZ-1:0]     dresp_rdata;

   modport master (
      output dreq_valid, dreq_addr, dreq_we, dreq_wdata, dreq_wstrb,
      input  dreq_ready, dresp_valid, dresp_rdata
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_we, dreq_wdata, dreq_wstrb,
      output dreq_ready, dresp_valid, dresp_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment shared by both paths: shifts store data/strobes into lane
// position and extracts plus sign/zero-extends load data from a doubleword.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [2:0]  off,
   input  logic [63:0] st_data,
   input  logic [63:0] ld_dword,
   output logic [63:0] st_wdata,
   output logic [7:0]  st_wstrb,
   output logic [63:0] ld_result
);

   logic [5:0]  lane_shift;
   logic [63:0] raw;

   assign lane_shift = {off, 3'b000};

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      ld_result = '0;
      st_wdata  = st_data << lane_shift;
      st_wstrb  = size_mask(funct3[1:0]) << off;
      raw       = ld_dword >> lane_shift;
      case (funct3)
         F3_B:    ld_result = {{56{raw[7]}},  raw[7:0]};
         F3_H:    ld_result = {{48{raw[15]}}, raw[15:0]};
         F3_W:    ld_result = {{32{raw[31]}}, raw[31:0]};
         F3_D:    ld_result = raw;
         F3_BU:   ld_result = {56'd0, raw[7:0]};
         F3_HU:   ld_result = {48'd0, raw[15:0]};
         F3_WU:   ld_result = {32'd0, raw[31:0]};
         default: ld_result = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store from the ALU, issues a single doubleword
// request, and hands aligned, extended load data to write-back.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDRSZ = 64,
   parameter int WORDSZ = 64,
   parameter int REGSZ  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_store,
   input  logic [2:0]        in_funct3,
   input  logic [ADDRSZ-1:0] in_addr,
   input  logic [WORDSZ-1:0] in_wdata,
   input  logic [REGSZ-1:0]  in_rd,
   lsu_dmem_if.master        dmem,
   output logic              out_valid,
   output logic              out_wr_en,
   output logic [REGSZ-1:0]  out_rd,
   output logic [WORDSZ-1:0] out_data,
   output logic              out_misaligned
);

   lsu_state_e        state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDRSZ-1:0] addr_q, addr_d;
   logic [WORDSZ-1:0] wdata_q, wdata_d;
   logic [REGSZ-1:0]  rd_q, rd_d;
   logic              fault_q, fault_d;
   logic [WORDSZ-1:0] rdata_q, rdata_d;

   logic [63:0]       st_wdata, ld_result;
   logic [7:0]        st_wstrb;
   logic              is_load_ok;

   lsu_align u_align (
      .funct3    (funct3_q),
      .off       (addr_q[2:0]),
      .st_data   (wdata_q),
      .ld_dword  (rdata_q),
      .st_wdata  (st_wdata),
      .st_wstrb  (st_wstrb),
      .ld_result (ld_result)
   );

   assign is_load_ok = !is_store_q && !fault_q;

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      fault_d    = fault_q;
      rdata_d    = rdata_q;
      case (state_q)
         S_IDLE: if (in_valid) begin
            is_store_d = in_is_store;
            funct3_d   = in_funct3;
            addr_d     = in_addr;
            wdata_d    = in_wdata;
            rd_d       = in_rd;
            fault_d    = access_fault(in_is_store, in_funct3, in_addr[2:0]);
            state_d    = fault_d ? S_DONE : S_REQ;
         end
         S_REQ:  if (dmem.dreq_ready) state_d = S_WAIT;
         S_WAIT: if (dmem.dresp_valid) begin
            rdata_d = dmem.dresp_rdata;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are gated by state so idle/reset values are zero regardless of latched data.
   always_comb begin
      in_ready        = (state_q == S_IDLE);
      dmem.dreq_valid = 1'b0;
      dmem.dreq_addr  = '0;
      dmem.dreq_we    = 1'b0;
      dmem.dreq_wdata = '0;
      dmem.dreq_wstrb = '0;
      out_valid       = 1'b0;
      out_wr_en       = 1'b0;
      out_rd          = '0;
      out_data        = '0;
      out_misaligned  = 1'b0;
      if (state_q == S_REQ) begin
         dmem.dreq_valid = 1'b1;
         dmem.dreq_addr  = {addr_q[ADDRSZ-1:3], 3'b000};
         dmem.dreq_we    = is_store_q;
         dmem.dreq_wdata = is_store_q ? st_wdata : '0;
         dmem.dreq_wstrb = is_store_q ? st_wstrb : '0;
      end
      if (state_q == S_DONE) begin
         out_valid      = 1'b1;
         out_wr_en      = is_load_ok && (rd_q != '0);
         out_rd         = rd_q;
         out_data       = is_load_ok ? ld_result : '0;
         out_misaligned = fault_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: datapath registers are not reset; they are always reloaded before use and every output is gated by state.
   always_ff @(posedge clk) begin
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for stores, loads,
// faults, back-pressure and reset in mid-transaction.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_is_store;
   logic [2:0]  in_funct3;
   logic [63:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        out_valid, out_wr_en, out_misaligned;
   logic [4:0]  out_rd;
   logic [63:0] out_data;

   lsu_dmem_if #(.ADDRSZ(64), .WORDSZ(64)) dmem ();

   load_store_unit #(.ADDRSZ(64), .WORDSZ(64), .REGSZ(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_is_store    (in_is_store),
      .in_funct3      (in_funct3),
      .in_addr        (in_addr),
      .in_wdata       (in_wdata),
      .in_rd          (in_rd),
      .dmem           (dmem),
      .out_valid      (out_valid),
      .out_wr_en      (out_wr_en),
      .out_rd         (out_rd),
      .out_data       (out_data),
      .out_misaligned (out_misaligned)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Captured results of the last run_op
   logic [63:0] r_addr, r_wdata, r_data;
   logic [7:0]  r_wstrb;
   logic [4:0]  r_rd;
   logic        r_we, r_seen, r_done, r_wr_en, r_mis, r_post_valid, r_post_ready;
   int          r_lat;

   // One op with an always-ready memory; latency counted from the accept cycle.
   task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata);
      in_valid         = 1'b1;
      in_is_store      = st;
      in_funct3        = f3;
      in_addr          = addr;
      in_wdata         = wdata;
      in_rd            = rd;
      dmem.dreq_ready  = 1'b1;
      dmem.dresp_valid = 1'b1;
      dmem.dresp_rdata = rdata;
      r_seen = 1'b0; r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0;
      tick();
      in_valid = 1'b0;
      r_lat = 1;
      while (!out_valid && r_lat < 20) begin
         if (dmem.dreq_valid) begin
            r_seen  = 1'b1;
            r_addr  = dmem.dreq_addr;
            r_wdata = dmem.dreq_wdata;
            r_wstrb = dmem.dreq_wstrb;
            r_we    = dmem.dreq_we;
         end
         tick();
         r_lat++;
      end
      r_done  = out_valid;
      r_data  = out_data;
      r_wr_en = out_wr_en;
      r_mis   = out_misaligned;
      r_rd    = out_rd;
      dmem.dresp_valid = 1'b0;
      tick();
      r_post_valid = out_valid;
      r_post_ready = in_ready;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
      in_addr = '0; in_wdata = '0; in_rd = '0;
      dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b0; dmem.dresp_rdata = '0;
      repeat (3) tick();
      check("rst_in_ready",   in_ready, 1);
      check("rst_dreq_valid", dmem.dreq_valid, 0);
      check("rst_dreq_addr",  dmem.dreq_addr, 0);
      check("rst_dreq_wstrb", dmem.dreq_wstrb, 0);
      check("rst_out_valid",  out_valid, 0);
      check("rst_out_data",   out_data, 0);
      check("rst_out_mis",    out_misaligned, 0);
      reset = 1'b0;
      tick();

      // SW at offset 4
      run_op(1'b1, F3_W, 64'h1004, 64'hDEAD_BEEF, 5'd1, 64'h0);
      check("sw_done",   r_done, 1);
      check("sw_lat",    r_lat, 3);
      check("sw_addr",   r_addr, 64'h1000);
      check("sw_we",     r_we, 1);
      check("sw_wdata",  r_wdata, 64'hDEAD_BEEF_0000_0000);
      check("sw_wstrb",  r_wstrb, 8'hF0);
      check("sw_wr_en",  r_wr_en, 0);
      check("sw_data",   r_data, 0);

      // LB / LBU at offset 3
      run_op(1'b0, F3_B, 64'h2003, 64'h0, 5'd5, 64'h0000_0000_8000_0000);
      check("lb_addr",   r_addr, 64'h2000);
      check("lb_we",     r_we, 0);
      check("lb_wstrb",  r_wstrb, 0);
      check("lb_data",   r_data, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_wr_en",  r_wr_en, 1);
      check("lb_rd",     r_rd, 5);
      run_op(1'b0, F3_BU, 64'h2003, 64'h0, 5'd5, 64'h0000_0000_8000_0000);
      check("lbu_data",  r_data, 64'h80);

      // LD to x0: no write-back, single pulse, 3-cycle latency
      run_op(1'b0, F3_D, 64'h3000, 64'h0, 5'd0, 64'h0123_4567_89AB_CDEF);
      check("ld_done",   r_done, 1);
      check("ld_lat",    r_lat, 3);
      check("ld_data",   r_data, 64'h0123_4567_89AB_CDEF);
      check("ld_wr_en",  r_wr_en, 0);
      check("ld_pulse",  r_post_valid, 0);
      check("ld_ready",  r_post_ready, 1);

      // LW / LWU in upper word
      run_op(1'b0, F3_W, 64'h5004, 64'h0, 5'd7, 64'h8765_4321_0000_0000);
      check("lw_data",   r_data, 64'hFFFF_FFFF_8765_4321);
      run_op(1'b0, F3_WU, 64'h5004, 64'h0, 5'd7, 64'h8765_4321_0000_0000);
      check("lwu_data",  r_data, 64'h8765_4321);

      // LH upper half with sign bit clear
      run_op(1'b0, F3_H, 64'h5006, 64'h0, 5'd9, 64'h7ABC_0000_0000_0000);
      check("lh_data",   r_data, 64'h7ABC);

      // SB at offset 5
      run_op(1'b1, F3_B, 64'h6005, 64'hAB, 5'd2, 64'h0);
      check("sb_addr",   r_addr, 64'h6000);
      check("sb_wdata",  r_wdata, 64'h0000_AB00_0000_0000);
      check("sb_wstrb",  r_wstrb, 8'h20);

      // Misaligned LH
      run_op(1'b0, F3_H, 64'h4001, 64'h0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      check("mis_lat",   r_lat, 1);
      check("mis_flag",  r_mis, 1);
      check("mis_seen",  r_seen, 0);
      check("mis_wr_en", r_wr_en, 0);
      check("mis_data",  r_data, 0);

      // Store with a load-only funct3 faults
      run_op(1'b1, F3_BU, 64'h6000, 64'h55, 5'd4, 64'h0);
      check("bad_st_flag", r_mis, 1);
      check("bad_st_seen", r_seen, 0);

      // Misaligned SD
      run_op(1'b1, F3_D, 64'h6004, 64'h55, 5'd4, 64'h0);
      check("mis_sd_flag", r_mis, 1);

      // Back-pressure: dreq_ready low for 5 cycles, stray response during REQ
      in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = F3_D;
      in_addr = 64'h8000; in_wdata = 64'h1122_3344_5566_7788; in_rd = 5'd3;
      dmem.dreq_ready = 1'b0; dmem.dresp_valid = 1'b0; dmem.dresp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", dmem.dreq_valid, 1);
         check("stall_addr",  dmem.dreq_addr, 64'h8000);
         check("stall_wdata", dmem.dreq_wdata, 64'h1122_3344_5566_7788);
         check("stall_wstrb", dmem.dreq_wstrb, 8'hFF);
         check("stall_ready", in_ready, 0);
         check("stall_out",   out_valid, 0);
         if (i == 1) dmem.dresp_valid = 1'b1;
         tick();
      end
      dmem.dresp_valid = 1'b0;
      dmem.dreq_ready  = 1'b1;
      tick();
      check("wait_dreq",  dmem.dreq_valid, 0);
      check("wait_out",   out_valid, 0);
      tick();
      check("wait_hold",  out_valid, 0);
      check("wait_ready", in_ready, 0);
      dmem.dresp_valid = 1'b1;
      tick();
      dmem.dresp_valid = 1'b0;
      check("stall_done",  out_valid, 1);
      check("stall_wr_en", out_wr_en, 0);
      check("stall_data",  out_data, 0);
      tick();
      check("stall_idle",  in_ready, 1);

      // Reset while in WAIT
      in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = F3_D;
      in_addr = 64'h7000; in_wdata = '0; in_rd = 5'd3;
      dmem.dreq_ready = 1'b1; dmem.dresp_valid = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      check("pre_rst_ready", in_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_dreq",  dmem.dreq_valid, 0);
      check("mrst_ready", in_ready, 1);
      check("mrst_out",   out_valid, 0);
      dmem.dresp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stale_out",   out_valid, 0);
         check("stale_ready", in_ready, 1);
      end
      dmem.dresp_valid = 1'b0;
      run_op(1'b0, F3_D, 64'h7008, 64'h0, 5'd3, 64'hCAFE_F00D_1234_5678);
      check("post_rst_lat",   r_lat, 3);
      check("post_rst_data",  r_data, 64'hCAFE_F00D_1234_5678);
      check("post_rst_wr_en", r_wr_en, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
